regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised integer register file for the Tiny RISC-V core: 2 combinational read
//   ports, 1 write port, hardwired-zero x0, optional write-to-read bypass.
//   Adds a per-register pending-write scoreboard: issue stage marks rd busy and
//   writeback clears it. The block flags RAW/WAW hazards so decode can stall.
// PARAMETERS
//   XLEN      32  data width of each register
//   NREG      32  number of registers (2..32, need not be a power of two)
//   AW        5   address width; must satisfy 2**AW >= NREG
//   BYPASS    1   1 = same-cycle write data forwarded to read ports and busy clear visible to hazard check
//   ZERO_REG  1   1 = register 0 reads 0, ignores writes, is never marked busy
// PORTS
//   clk            in   1     clock, rising edge
//   rst            in   1     reset, asynchronous, active-low
//   dir1           in   AW    read address, port 1
//   dir2           in   AW    read address, port 2
//   rs1            out  XLEN  read data, port 1 (combinational)
//   rs2            out  XLEN  read data, port 2 (combinational)
//   we             in   1     write enable (writeback)
//   wr             in   AW    write address
//   info           in   XLEN  write data
//   issue_valid    in   1     decode presents an instruction this cycle
//   issue_rd       in   AW    destination of issuing instruction
//   issue_wb       in   1     issuing instruction writes rd
//   issue_rs1      in   AW    source 1 of issuing instruction
//   issue_rs2      in   AW    source 2 of issuing instruction
//   issue_use1     in   1     source 1 is read
//   issue_use2     in   1     source 2 is read
//   flush          in   1     pipeline flush: drop all pending writes
//   hazard         out  1     issuing instruction must stall (combinational)
//   busy_count     out  AW+1  number of busy registers (combinational from state)
// BEHAVIOUR
//   - State: mem[NREG] of XLEN, busy[NREG]. rst low -> all mem and busy cleared
//     immediately; outputs then: rs1/rs2 = 0, hazard = 0, busy_count = 0.
//   - Read: addr >= NREG or (ZERO_REG and addr==0) -> 0. Else if BYPASS and we and
//     wr==addr and wr write-legal -> info (0-cycle forward). Else mem[addr].
//   - Write: on posedge if we, wr < NREG, !(ZERO_REG && wr==0): mem[wr] <= info.
//     Illegal writes are silently dropped.
//   - clr = we and wr legal (as above); set = issue_valid & issue_wb & !hazard &
//     issue_rd legal.
//   - busy_eff[i] = busy[i] & !(BYPASS & clr & wr==i).
//   - hazard = issue_valid & ((issue_use1 & busy_eff[issue_rs1]) |
//     (issue_use2 & busy_eff[issue_rs2]) | (issue_wb & busy_eff[issue_rd])).
//     Out-of-range or zero (ZERO_REG) sources/dest never hazard.
//   - Busy update at posedge, priority: flush (all busy <= 0, set ignored) >
//     set (busy[issue_rd] <= 1, wins over clr on same index) > clr (busy[wr] <= 0).
//   - we on a non-busy register is legal: data written, busy unchanged.
//   - busy_count = popcount(busy); reaches NREG-ZERO_REG max, never wraps.
//   - Reset asserted mid-operation aborts everything; first edge after release
//     behaves as from empty state.
// TESTING
//   1 Reset: write x5=0xDEADBEEF, pulse rst low -> rs1(dir1=5)=0, busy_count=0.
//   2 x0: we=1 wr=0 info=0x1234 -> dir1=0 reads 0; issue rd=0 -> busy_count stays 0.
//   3 Bypass: we=1 wr=7 info=0xA5A5A5A5, dir2=7 same cycle -> rs2=0xA5A5A5A5
//     (BYPASS=1); old value with BYPASS=0; both modes read 0xA5A5A5A5 next cycle.
//   4 RAW: issue rd=3 -> busy_count=1; next cycle issue rs1=3 use1 -> hazard=1;
//     we wr=3 same cycle -> hazard=0 (BYPASS=1) / 1 (BYPASS=0); busy_count=0 after.
//   5 Simultaneous: busy[4]=1, we wr=4 and issue rd=4 wb (no hazard, BYPASS=1)
//     -> busy[4] stays 1; add flush=1 -> busy_count=0 next cycle.
//   6 NREG=20: dir1=25 reads 0, we wr=25 dropped, issue rd=25 -> no busy, no hazard.

Source files
------------

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// regfile_scoreboard : integer register file with per-register pending-write
//                      scoreboard and RAW/WAW hazard detection for decode.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   dir1,
  input  logic [AW-1:0]   dir2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            we,
  input  logic [AW-1:0]   wr,
  input  logic [XLEN-1:0] info,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wb,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            issue_use1,
  input  logic            issue_use2,
  input  logic            flush,
  output logic            hazard,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            w_clr;
  logic            w_set;
  logic [NREG-1:0] w_busy_eff;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_hzd;

  // An address is usable when it exists and is not the hardwired zero register.
  function automatic logic legal(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREG)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_clr = we && legal(wr);

  assign rs1 = !legal(dir1)                              ? '0   :
               ((BYPASS != 0) && w_clr && (wr == dir1)) ? info : mem_q[dir1];
  assign rs2 = !legal(dir2)                              ? '0   :
               ((BYPASS != 0) && w_clr && (wr == dir2)) ? info : mem_q[dir2];

  always_comb begin
    w_busy_eff = busy_q;
    if ((BYPASS != 0) && w_clr) begin
      w_busy_eff[wr] = 1'b0;
    end
  end

  assign w_hz1  = issue_use1 && legal(issue_rs1) && w_busy_eff[issue_rs1];
  assign w_hz2  = issue_use2 && legal(issue_rs2) && w_busy_eff[issue_rs2];
  assign w_hzd  = issue_wb   && legal(issue_rd)  && w_busy_eff[issue_rd];
  assign hazard = issue_valid && (w_hz1 || w_hz2 || w_hzd);

  assign w_set = issue_valid && issue_wb && !hazard && legal(issue_rd);

  // Set is applied after clear so a new issue to the same rd stays pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (w_clr) begin
        busy_d[wr] = 1'b0;
      end
      if (w_set) begin
        busy_d[issue_rd] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_count = busy_count + {{AW{1'b0}}, busy_q[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (w_clr) begin
        mem_q[wr] <= info;
      end
      busy_q <= busy_d;
    end
  end

endmodule

`default_nettype wire
